// File: rtl/top_result_accumulator.sv
// Result-stream accumulator: folds a configured number of pipeline result words
// into per-top totals and hands out one totals record per top.
module top_result_accumulator #(
    parameter int unsigned SUM_WIDTH    = 64,
    parameter int unsigned PCOEFF_WIDTH = 40,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [COUNT_WIDTH-1:0]  cfgCount,
    input  logic                    resValid,
    output logic                    resReady,
    input  logic [63:0]             resData,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [SUM_WIDTH-1:0]    outSum,
    output logic [PCOEFF_WIDTH-1:0] outPcoeffCount,
    output logic [COUNT_WIDTH-1:0]  outResultCount,
    output logic [22:0]             outElapsed,
    output logic                    outOverflow
);
    localparam int unsigned STAMP_WIDTH  = 23;
    localparam int unsigned SUMMED_WIDTH = 38;
    localparam int unsigned PC_IN_WIDTH  = 3;
    localparam int unsigned SUM_EXT      = SUM_WIDTH + 1;
    localparam int unsigned PC_EXT       = PCOEFF_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [STAMP_WIDTH-1:0]  res_stamp;
    logic [PC_IN_WIDTH-1:0]  res_pcoeff;
    logic [SUMMED_WIDTH-1:0] res_summed;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [STAMP_WIDTH-1:0]  first_stamp;
    logic                    first_flag;
    logic                    cfg_fire;
    logic                    res_fire;
    logic                    last_word;
    logic [SUM_EXT-1:0]      sum_wide;
    logic [PC_EXT-1:0]       pc_wide;

    assign res_stamp  = resData[63:41];
    assign res_pcoeff = resData[40:38];
    assign res_summed = resData[37:0];

    assign cfg_fire  = cfgValid && cfgReady;
    assign res_fire  = resValid && resReady;
    assign last_word = (remaining == COUNT_WIDTH'(1));

    // One extra bit on each adder exposes the carry-out that feeds the sticky overflow.
    assign sum_wide = {1'b0, outSum} + SUM_EXT'(res_summed);
    assign pc_wide  = {1'b0, outPcoeffCount} + PC_EXT'(res_pcoeff);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfgValid) state_next = (cfgCount == '0) ? DONE : ACCUM;
            ACCUM:   if (resValid && last_word) state_next = DONE;
            DONE:    if (outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfgReady = 1'b0;
        resReady = 1'b0;
        outValid = 1'b0;
        case (state)
            IDLE:    cfgReady = 1'b1;
            ACCUM:   resReady = 1'b1;
            DONE:    outValid = 1'b1;
            default: ;
        endcase
    end

    // Running totals double as the output record; they hold until the next job clears them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            remaining      <= '0;
            first_flag     <= 1'b0;
            first_stamp    <= '0;
            outSum         <= '0;
            outPcoeffCount <= '0;
            outResultCount <= '0;
            outElapsed     <= '0;
            outOverflow    <= 1'b0;
        end else if (cfg_fire) begin
            remaining      <= cfgCount;
            first_flag     <= 1'b1;
            first_stamp    <= '0;
            outSum         <= '0;
            outPcoeffCount <= '0;
            outResultCount <= '0;
            outElapsed     <= '0;
            outOverflow    <= 1'b0;
        end else if (res_fire) begin
            remaining      <= remaining - COUNT_WIDTH'(1);
            first_flag     <= 1'b0;
            outSum         <= sum_wide[SUM_WIDTH-1:0];
            outPcoeffCount <= pc_wide[PCOEFF_WIDTH-1:0];
            outResultCount <= outResultCount + COUNT_WIDTH'(1);
            outOverflow    <= outOverflow | sum_wide[SUM_WIDTH] | pc_wide[PCOEFF_WIDTH];
            if (first_flag) begin
                first_stamp <= res_stamp;
                outElapsed  <= '0;
            end else begin
                outElapsed  <= res_stamp - first_stamp;
            end
        end
    end

endmodule
